// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity frame receiver and its matching transmitter.
package parity_rx_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // True when the XOR reduction over data and parity matches the selected sense.
    // Narrower words are zero-extended, which leaves the reduction unchanged.
    function automatic logic parity_ok(input logic [31:0] data, input logic par, input logic odd);
        return ((^data) ^ par) == odd;
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Word-level valid/ready output bus of the frame receiver.
interface parity_frame_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_parity_err;
    logic              out_frame_err;

    modport master (
        output out_data, out_valid, out_parity_err, out_frame_err,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_parity_err, out_frame_err,
        output out_ready
    );
endinterface

// File: rtl/parity_frame_rx_outreg.sv
// Output holding register: loads completed frames, releases them on ready,
// and flags frames that arrive while a word is still held.
module parity_frame_rx_outreg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              perr_i,
    input  logic              ferr_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              perr_o,
    output logic              ferr_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;
    logic              overrun_q;

    // Load wins over consume so a word taken in the same cycle is replaced with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= load_i && valid_q && !ready_i;
            if (load_i && (!valid_q || ready_i)) begin
                data_q  <= data_i;
                perr_q  <= perr_i;
                ferr_q  <= ferr_i;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign ferr_o    = ferr_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, parity, stop.
// Deserialises the word, checks parity and framing, hands off on valid/ready.
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    parity_frame_rx_if.master        out,
    output logic                     overrun,
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    rx_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;

    logic              frame_stb;
    logic              frame_perr;
    logic              frame_ferr;

    // Frame FSM with bit counter and shift register; advances only on sampled bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else if (bit_valid) begin
            case (state_q)
                RX_IDLE: begin
                    if (bit_in == START_BIT) begin
                        state_q <= RX_DATA;
                        cnt_q   <= '0;
                    end
                end
                RX_DATA: begin
                    shift_q <= {bit_in, shift_q[DATA_W-1:1]};
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_q   <= bit_in;
                    state_q <= RX_STOP;
                end
                RX_STOP: begin
                    state_q <= RX_IDLE;
                end
                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    // The stop bit itself completes the frame; the holding register loads on that step.
    assign frame_stb  = bit_valid && (state_q == RX_STOP);
    assign frame_ferr = (bit_in != STOP_BIT);
    assign frame_perr = !parity_ok(32'(shift_q), par_q, PARITY_ODD);
    assign busy       = (state_q != RX_IDLE);

    parity_frame_rx_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (frame_stb),
        .data_i    (shift_q),
        .perr_i    (frame_perr),
        .ferr_i    (frame_ferr),
        .ready_i   (out.out_ready),
        .data_o    (out.out_data),
        .valid_o   (out.out_valid),
        .perr_o    (out.out_parity_err),
        .ferr_o    (out.out_frame_err),
        .overrun_o (overrun)
    );

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: even-parity DUT under test, odd-parity
// twin sharing the serial stimulus for the parity-sense check.
module tb_parity_frame_rx;

    logic clk;
    logic rst;
    logic bit_valid;
    logic bit_in;
    logic overrun;
    logic busy;
    logic overrun2;
    logic busy2;

    int unsigned n_vec;
    int unsigned n_err;

    parity_frame_rx_if #(.DATA_W(8)) rx_if ();
    parity_frame_rx_if #(.DATA_W(8)) rx_if2 ();

    parity_frame_rx #(
        .DATA_W     (8),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .out       (rx_if),
        .overrun   (overrun),
        .busy      (busy)
    );

    parity_frame_rx #(
        .DATA_W     (8),
        .PARITY_ODD (1'b1)
    ) dut_odd (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .out       (rx_if2),
        .overrun   (overrun2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles carry the inverted bit to show bit_in is ignored without bit_valid.
    task automatic send_bit(input logic b, input int unsigned gap);
        for (int unsigned g = 0; g < gap; g++) begin
            bit_valid = 1'b0;
            bit_in    = ~b;
            tick();
        end
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    task automatic send_body(input logic [7:0] data, input logic par, input int unsigned gap);
        logic [7:0] d;
        d = data;
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(par, gap);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        send_body(data, par, 0);
        send_bit(stop, 0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        rx_if.out_ready  = 1'b1;
        rx_if2.out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_valid",   32'(rx_if.out_valid), 0);
        chk("rst_data",    32'(rx_if.out_data), 0);
        chk("rst_perr",    32'(rx_if.out_parity_err), 0);
        chk("rst_ferr",    32'(rx_if.out_frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_busy_odd", 32'(busy2 | overrun2 | rx_if2.out_frame_err), 0);
        rst = 1'b0;
        tick();

        // 1: clean 0xA5, visible the cycle after the stop bit, for one cycle
        send_body(8'hA5, 1'b0, 0);
        chk("t1_busy_before_stop", 32'(busy), 1);
        chk("t1_valid_before_stop", 32'(rx_if.out_valid), 0);
        send_bit(1'b1, 0);
        chk("t1_valid", 32'(rx_if.out_valid), 1);
        chk("t1_data",  32'(rx_if.out_data), 32'hA5);
        chk("t1_perr",  32'(rx_if.out_parity_err), 0);
        chk("t1_ferr",  32'(rx_if.out_frame_err), 0);
        chk("t1_busy",  32'(busy), 0);
        chk("t1_odd_perr", 32'(rx_if2.out_parity_err), 1);
        tick();
        chk("t1_valid_drop", 32'(rx_if.out_valid), 0);

        // 2: wrong parity for even sense, correct for odd sense
        send_frame(8'hA5, 1'b1, 1'b1);
        chk("t2_data", 32'(rx_if.out_data), 32'hA5);
        chk("t2_perr", 32'(rx_if.out_parity_err), 1);
        chk("t2_odd_data", 32'(rx_if2.out_data), 32'hA5);
        chk("t2_odd_perr", 32'(rx_if2.out_parity_err), 0);
        tick();

        // 3: framing error, then clean frame clears it
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("t3_valid", 32'(rx_if.out_valid), 1);
        chk("t3_data",  32'(rx_if.out_data), 32'h3C);
        chk("t3_ferr",  32'(rx_if.out_frame_err), 1);
        chk("t3_perr",  32'(rx_if.out_parity_err), 0);
        tick();
        send_frame(8'h0F, 1'b0, 1'b1);
        chk("t3b_data", 32'(rx_if.out_data), 32'h0F);
        chk("t3b_ferr", 32'(rx_if.out_frame_err), 0);
        chk("t3b_perr", 32'(rx_if.out_parity_err), 0);
        tick();

        // 4: overrun while output is held
        rx_if.out_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("t4_valid",   32'(rx_if.out_valid), 1);
        chk("t4_data",    32'(rx_if.out_data), 32'h3C);
        chk("t4_no_ovr",  32'(overrun), 0);
        send_frame(8'h0F, 1'b0, 1'b1);
        chk("t4_ovr",     32'(overrun), 1);
        chk("t4_hold",    32'(rx_if.out_data), 32'h3C);
        chk("t4_valid2",  32'(rx_if.out_valid), 1);
        tick();
        chk("t4_ovr_end", 32'(overrun), 0);
        chk("t4_hold2",   32'(rx_if.out_data), 32'h3C);
        rx_if.out_ready = 1'b1;
        tick();
        chk("t4_drop",    32'(rx_if.out_valid), 0);
        tick();
        tick();
        chk("t4_no_0f",   32'(rx_if.out_valid), 0);

        // 5: reset mid-frame loses the partial frame and the held word
        rx_if.out_ready = 1'b0;
        send_frame(8'h12, 1'b0, 1'b1);
        chk("t5_held", 32'(rx_if.out_valid), 1);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        chk("t5_busy_mid", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_valid", 32'(rx_if.out_valid), 0);
        chk("t5_data_clr", 32'(rx_if.out_data), 0);
        rx_if.out_ready = 1'b1;
        send_frame(8'h81, 1'b0, 1'b1);
        chk("t5_data", 32'(rx_if.out_data), 32'h81);
        chk("t5_flags", 32'({rx_if.out_parity_err, rx_if.out_frame_err}), 0);
        tick();

        // 6: gapped 0x55 held, back-to-back 0xAA replaces it on a consume
        rx_if.out_ready = 1'b0;
        send_body(8'h55, 1'b0, 2);
        send_bit(1'b1, 2);
        chk("t6_valid", 32'(rx_if.out_valid), 1);
        chk("t6_data55", 32'(rx_if.out_data), 32'h55);
        send_body(8'hAA, 1'b0, 0);
        chk("t6_still55", 32'(rx_if.out_data), 32'h55);
        rx_if.out_ready = 1'b1;
        send_bit(1'b1, 0);
        chk("t6_valid_kept", 32'(rx_if.out_valid), 1);
        chk("t6_dataAA", 32'(rx_if.out_data), 32'hAA);
        chk("t6_no_ovr", 32'(overrun), 0);
        tick();
        chk("t6_drop", 32'(rx_if.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
